hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-detection unit for the multi-stage MIPS pipeline. It tracks every in-flight register writer downstream of Decode in a shifting scoreboard, with a per-entry Tnew countdown. It also tracks a multi-cycle mult/div unit with a busy counter. Each cycle it compares the Decode-stage instruction's source registers and Tuse values against the scoreboard and asserts a stall, which freezes PC/F/D and injects a bubble into E. It replaces the purely combinational per-stage Tuse/Tnew stall logic: pipeline depth is now generic, the stall bubble is generated internally, HI/LO busy stalls are supported, and dual-candidate destinations (conditional-write loads) are supported.

## Interface
- NSTAGE, 2: number of tracked stages after D (entry 0 = E, entry NSTAGE-1 = last stage with Tnew possibly > 0)
- AW, 5: register address width
- TW, 3: Tnew/Tuse width
- MULT_LAT, 5: mult/multu busy cycles
- DIV_LAT, 10: div/divu busy cycles

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- d_valid  in  1  D holds a real instruction
- d_rs, d_rt  in  AW  D source registers (0 = unused)
- d_tuse_rs, d_tuse_rt  in  TW  D Tuse per source (max value = unused)
- d_wa  in  AW  D destination (0 = no write)
- d_wa_alt  in  AW  second candidate destination
- d_wa_alt_en  in  1  destination is d_wa OR d_wa_alt, resolved after E
- d_tnew  in  TW  Tnew of D instruction as it will be in E (calc 1, load 2, link 0)
- d_md_use  in  1  D instruction touches mult/div/HI/LO (includes starts)
- d_md_start  in  1  D instruction launches mult/div
- d_md_div  in  1  with d_md_start: division (DIV_LAT) vs multiply (MULT_LAT)
- stall  out  1  stall_reg | stall_md
- stall_reg  out  1  register (Tnew/Tuse) hazard
- stall_md  out  1  mult/div busy hazard
- md_busy  out  1  md_cnt != 0
- md_cnt  out  clog2(DIV_LAT+1)  remaining busy cycles

## Operation
- Entry fields: valid, wa, wa_alt, alt_en, tnew.
- Match(src, entry) is true when all of the following hold:
  - src != 0
  - entry.valid
  - src == entry.wa, or (entry.alt_en and src == entry.wa_alt)
- stall_reg = d_valid and, for some entry i, one of:
  - Match(d_rs, i) and tnew_i > d_tuse_rs
  - Match(d_rt, i) and tnew_i > d_tuse_rt
- A write to register 0 never matches. A d_wa_alt with alt_en=0 is ignored.
- Shift every cycle, each edge:
  - for i ≥ 1: entry[i] <= entry[i-1], with tnew decremented and saturating at 0
  - the last entry's old contents are dropped
- Entry 0 load, each edge:
  - when stall=1 or d_valid=0: entry[0] <= bubble (valid=0)
  - otherwise: entry[0] <= {1, d_wa, d_wa_alt, d_wa_alt_en, d_tnew}
- stall_md = d_valid & d_md_use & md_busy.
- md_cnt rules:
  - accept of an instruction with d_md_start (d_valid & d_md_start & ~stall) loads md_cnt <= d_md_div ? DIV_LAT : MULT_LAT
  - otherwise md_cnt decrements when nonzero
  - the load takes priority over the decrement
- A start is never accepted while busy: d_md_start implies d_md_use, so it stalls.
- The unit is state-only: it never inspects instruction bits, and the decoder supplies all fields.

## Timing
- Reset (asynchronous, reset_n=0): all entries valid=0, tnew=0, md_cnt=0. md_busy=0, stall_md=0, stall_reg=0, stall=0 while reset is held and afterwards until state exists.
- stall, stall_reg, stall_md are combinational from D inputs and current state, in the same cycle.
- Scoreboard and counter update one edge after an accept.
- Writer-to-reader spacing:
  - a load (d_tnew=2) followed immediately by a Tuse=1 consumer stalls exactly 1 cycle (E tnew 2 > 1; next cycle M tnew 1 ≤ 1)
  - a Tuse=0 consumer (branch) behind a calc stalls 1 cycle; behind a load, 2 cycles
- Busy window: a mult accepted at edge k makes md_busy high for cycles k+1 … k+MULT_LAT, and an md_use instruction in D is released in cycle k+MULT_LAT+1.
- Reset mid-operation clears all entries and md_cnt immediately. No stale stalls remain after release.
- Stall held indefinitely: bubbles keep filling entry 0 and older writers drain normally, so the stall must self-resolve within max(d_tnew) cycles (register) or DIV_LAT cycles (md).

## Test plan
- Reset: hold reset_n=0 with d_valid=1, d_rs=5, earlier writers loaded → stall=0, md_cnt=0. After release, a consumer of $5 with no writer → no stall.
- Load-use: accept lw $8 (d_wa=8, d_tnew=2), then D = addu reading rs=8, Tuse=1 → stall=1 for exactly 1 cycle. Entry 0 becomes a bubble, then stall=0. The same case with beq (Tuse=0) → 2 stall cycles.
- $0 and alt destination:
  - writer d_wa=0 followed by a reader of $0 → never stalls
  - writer d_wa=9, d_wa_alt=31, alt_en=1, d_tnew=2, followed by a reader of rs=31, Tuse=1 → 1-cycle stall
  - a reader of rs=10 behind the same writer → no stall
- Mult/div busy:
  - accept div (DIV_LAT=10), then D = mflo → stall_md=1 for 10 cycles with md_cnt counting 10…1, released when md_cnt=0
  - a non-md D instruction in the same window → no stall
- Depth generic: NSTAGE=4 with d_tnew=3 writer, reader Tuse=0 → 3 stall cycles; tnew saturates at 0 in deeper entries, and no stall occurs after draining.
- Reset mid-stall: assert reset_n=0 during the 5th cycle of a div busy window → md_busy=0, stall=0 immediately, and all entries are invalid after release.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight register writers after Decode
// with a per-entry Tnew countdown, plus a mult/div busy counter, and raises a
// combinational stall for the Decode-stage instruction.
// Latency: stall outputs are same-cycle combinational; state updates one edge after accept.
// Backpressure: stall freezes PC/F/D; a bubble is injected into entry 0 (E) while stalled.
//
// Ports:
//   clk, reset_n             clock / async active-low reset
//   d_valid                  D holds a real instruction
//   d_rs, d_rt               D source registers (0 = unused)
//   d_tuse_rs, d_tuse_rt     Tuse per source (all-ones = unused)
//   d_wa, d_wa_alt           destination and alternate destination
//   d_wa_alt_en              destination is d_wa or d_wa_alt (resolved after E)
//   d_tnew                   Tnew of the D instruction as seen in E
//   d_md_use/start/div       mult/div usage, launch, and divide select
//   stall, stall_reg, stall_md, md_busy, md_cnt   hazard outputs / busy state
module hazard_scoreboard #(
  parameter  int NSTAGE   = 2,
  parameter  int AW       = 5,
  parameter  int TW       = 3,
  parameter  int MULT_LAT = 5,
  parameter  int DIV_LAT  = 10,
  localparam int CW       = $clog2(DIV_LAT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_wa,
  input  logic [AW-1:0] d_wa_alt,
  input  logic          d_wa_alt_en,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_use,
  input  logic          d_md_start,
  input  logic          d_md_div,
  output logic          stall,
  output logic          stall_reg,
  output logic          stall_md,
  output logic          md_busy,
  output logic [CW-1:0] md_cnt
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] wa;
    logic [AW-1:0] wa_alt;
    logic          alt_en;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t        sb_q [NSTAGE];
  entry_t        sb_d [NSTAGE];
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          reg_hit;

  // Register 0 is never a real dependency; the alternate destination only
  // counts when the writer declared it as a candidate.
  function automatic logic src_match(input logic [AW-1:0] src, input entry_t e);
    return (src != '0) && e.valid &&
           ((src == e.wa) || (e.alt_en && (src == e.wa_alt)));
  endfunction

  always_comb begin
    reg_hit = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (src_match(d_rs, sb_q[i]) && (sb_q[i].tnew > d_tuse_rs)) reg_hit = 1'b1;
      if (src_match(d_rt, sb_q[i]) && (sb_q[i].tnew > d_tuse_rt)) reg_hit = 1'b1;
    end
  end

  assign md_busy   = (md_cnt_q != '0);
  assign md_cnt    = md_cnt_q;
  assign stall_reg = d_valid & reg_hit;
  assign stall_md  = d_valid & d_md_use & md_busy;
  assign stall     = stall_reg | stall_md;

  // Next state: everything advances one stage every cycle regardless of the
  // stall, so older writers drain and a held stall always resolves itself.
  always_comb begin
    for (int i = 0; i < NSTAGE; i++) sb_d[i] = '0;
    for (int i = 1; i < NSTAGE; i++) begin
      sb_d[i] = sb_q[i-1];
      if (sb_q[i-1].tnew != '0) sb_d[i].tnew = sb_q[i-1].tnew - TW'(1);
    end
    if (d_valid && !stall) begin
      sb_d[0].valid  = 1'b1;
      sb_d[0].wa     = d_wa;
      sb_d[0].wa_alt = d_wa_alt;
      sb_d[0].alt_en = d_wa_alt_en;
      sb_d[0].tnew   = d_tnew;
    end

    // A start can only be accepted when idle (it also asserts md_use), so
    // the load never overlaps a running operation.
    md_cnt_d = md_cnt_q;
    if (d_valid && d_md_start && !stall)
      md_cnt_d = d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSTAGE; i++) sb_q[i] <= '0;
      md_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) sb_q[i] <= sb_d[i];
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a 2-stage and a 4-stage instance
// share the same Decode stimulus; expected outputs are queued per step and
// compared against the DUT on the falling edge.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa, d_wa_alt;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_wa_alt_en, d_md_use, d_md_start, d_md_div;

  logic       stall, stall_reg, stall_md, md_busy;
  logic [3:0] md_cnt;
  logic       stall4, stall_reg4, stall_md4, md_busy4;
  logic [3:0] md_cnt4;

  int n_chk = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.NSTAGE(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_wa_alt(d_wa_alt), .d_wa_alt_en(d_wa_alt_en), .d_tnew(d_tnew),
    .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .stall_reg(stall_reg), .stall_md(stall_md),
    .md_busy(md_busy), .md_cnt(md_cnt)
  );

  hazard_scoreboard #(.NSTAGE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_wa_alt(d_wa_alt), .d_wa_alt_en(d_wa_alt_en), .d_tnew(d_tnew),
    .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall4), .stall_reg(stall_reg4), .stall_md(stall_md4),
    .md_busy(md_busy4), .md_cnt(md_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [2:0] trs,
                       input logic [4:0] rt, input logic [2:0] trt,
                       input logic [4:0] wa, input logic [4:0] alt, input logic alten,
                       input logic [2:0] tnew, input logic mu, input logic ms,
                       input logic mdiv);
    d_valid = v; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_wa = wa; d_wa_alt = alt; d_wa_alt_en = alten; d_tnew = tnew;
    d_md_use = mu; d_md_start = ms; d_md_div = mdiv;
  endtask

  task automatic wr(input logic [4:0] wa, input logic [2:0] tnew);
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, wa, 5'd0, 1'b0, tnew, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] rs, input logic [2:0] tuse);
    set_d(1'b1, rs, tuse, 5'd0, 3'd7, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue the expectation for this cycle, compare mid-cycle, advance to just
  // after the next rising edge.
  task automatic step(input string tag, input logic es, input logic esr,
                      input logic esm, input int cnt, input logic es4);
    logic [8:0] want;
    string      t;
    exp_q.push_back({es4, es, esr, esm, (cnt != 0), 4'(cnt)});
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    chk(t, {23'd0, stall4, stall, stall_reg, stall_md, md_busy, md_cnt}, {23'd0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic es, input logic esr,
                    input logic esm, input int cnt);
    step(tag, es, esr, esm, cnt, es);
  endtask

  initial begin
    reset_n = 1'b0;
    rd(5'd5, 3'd1);
    @(posedge clk); #1;
    st("rst_hold", 0, 0, 0, 0);
    reset_n = 1'b1;

    // Writer of $5 loaded, then reset with a dependent reader in D.
    wr(5'd5, 3'd2);          st("w5", 0, 0, 0, 0);
    rd(5'd5, 3'd1);
    reset_n = 1'b0;          st("rst_loaded", 0, 0, 0, 0);
    reset_n = 1'b1;          st("rd5_after_rst", 0, 0, 0, 0);

    // Load-use: Tuse=1 stalls one cycle.
    wr(5'd8, 3'd2);          st("lw8", 0, 0, 0, 0);
    rd(5'd8, 3'd1);          st("lu_stall", 1, 1, 0, 0);
                             st("lu_rel", 0, 0, 0, 0);
    // Branch (Tuse=0) behind load: two cycles.
    wr(5'd8, 3'd2);          st("lw8b", 0, 0, 0, 0);
    rd(5'd8, 3'd0);          st("beq_s1", 1, 1, 0, 0);
                             st("beq_s2", 1, 1, 0, 0);
                             st("beq_rel", 0, 0, 0, 0);
    // Branch behind calc via rt: one cycle.
    wr(5'd12, 3'd1);         st("calc12", 0, 0, 0, 0);
    set_d(1'b1, 5'd0, 3'd7, 5'd12, 3'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
                             st("rt_stall", 1, 1, 0, 0);
                             st("rt_rel", 0, 0, 0, 0);

    // Register 0 never matches.
    wr(5'd0, 3'd2);          st("w0", 0, 0, 0, 0);
    set_d(1'b1, 5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
                             st("rd0", 0, 0, 0, 0);

    // Alternate destination.
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd9, 5'd31, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
                             st("walt", 0, 0, 0, 0);
    rd(5'd31, 3'd1);         st("alt_stall", 1, 1, 0, 0);
                             st("alt_rel", 0, 0, 0, 0);
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd9, 5'd31, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
                             st("walt2", 0, 0, 0, 0);
    rd(5'd10, 3'd1);         st("alt_other", 0, 0, 0, 0);
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd9, 5'd31, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
                             st("walt_dis", 0, 0, 0, 0);
    rd(5'd31, 3'd1);         st("alt_dis_rd", 0, 0, 0, 0);

    // Divide busy window with a non-md instruction inside it.
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
                             st("div_acc", 0, 0, 0, 0);
    rd(5'd3, 3'd1);          st("nonmd_busy", 0, 0, 0, 10);
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 9; k >= 1; k--) st($sformatf("mflo_div_%0d", k), 1, 0, 1, k);
                             st("mflo_div_rel", 0, 0, 0, 0);

    // Multiply busy window.
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
                             st("mult_acc", 0, 0, 0, 0);
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 5; k >= 1; k--) st($sformatf("mflo_mul_%0d", k), 1, 0, 1, k);
                             st("mflo_mul_rel", 0, 0, 0, 0);

    // Depth: Tnew=3 writer, Tuse=0 reader. 2-stage sees 2 cycles, 4-stage 3.
    wr(5'd20, 3'd3);         st("w20_t3", 0, 0, 0, 0);
    rd(5'd20, 3'd0);
    step("deep_1", 1, 1, 0, 0, 1);
    step("deep_2", 1, 1, 0, 0, 1);
    step("deep_3", 0, 0, 0, 0, 1);
    step("deep_rel", 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) st($sformatf("deep_drain_%0d", k), 0, 0, 0, 0);

    // Reset in the 5th cycle of a divide busy window.
    wr(5'd21, 3'd2);         st("w21", 0, 0, 0, 0);
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
                             st("div2_acc", 0, 0, 0, 0);
    set_d(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 10; k >= 7; k--) st($sformatf("div2_busy_%0d", k), 1, 0, 1, k);
    reset_n = 1'b0;          st("rst_mid", 0, 0, 0, 0);
                             st("rst_mid_hold", 0, 0, 0, 0);
    reset_n = 1'b1;
    set_d(1'b1, 5'd21, 3'd0, 5'd0, 3'd7, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
                             st("post_rst_rd", 0, 0, 0, 0);
                             st("post_rst_rd2", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
